// File: rtl/branch_predictor_btb_pkg.sv
// Shared constants, update-kind encoding and PC field extraction for the
// branch target buffer and its counters.
package branch_predictor_btb_pkg;

   localparam int MAX_CTR_BITS = 4;

   typedef enum logic [1:0] {
      UPD_NONE,
      UPD_HIT_INC,
      UPD_HIT_DEC,
      UPD_ALLOC
   } upd_kind_e;

   // Weakly not-taken is 01..1, weakly taken is 10..0.
   function automatic logic [MAX_CTR_BITS-1:0] ctr_weak_nt(input int bits);
      return MAX_CTR_BITS'((1 << (bits - 1)) - 1);
   endfunction

   function automatic logic [MAX_CTR_BITS-1:0] ctr_weak_t(input int bits);
      return MAX_CTR_BITS'(1 << (bits - 1));
   endfunction

   function automatic int entry_width(input int xlen, input int tag_bits, input int ctr_bits);
      return 1 + tag_bits + xlen + ctr_bits;
   endfunction

   function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_bits);
      return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
   endfunction

   function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_bits,
                                          input int tag_bits);
      return (pc >> (idx_bits + 2)) & ((64'd1 << tag_bits) - 64'd1);
   endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down counter with synchronous clear and load; used for the
// per-entry direction history and for the performance counters.
module sat_counter #(
   parameter int            W       = 2,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_i,
   input  logic          inc_i,
   input  logic          dec_i,
   input  logic          load_i,
   input  logic [W-1:0]  load_val_i,
   output logic [W-1:0]  cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = RST_VAL;
      else if (load_i)
         cnt_d = load_val_i;
      else if (inc_i && (cnt_q != '1))
         cnt_d = cnt_q + W'(1);
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= RST_VAL;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters; zero-latency lookup, read-before-write training, single-cycle flush.
module branch_predictor_btb
   import branch_predictor_btb_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter int ENTRIES  = 16,
   parameter int CTR_BITS = 2,
   parameter int TAG_BITS = 8,
   parameter int PERF_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   fetch_pc,
   output logic              pred_taken,
   output logic [XLEN-1:0]   pred_target,
   input  logic              upd_valid,
   input  logic [XLEN-1:0]   upd_pc,
   input  logic              upd_taken,
   input  logic [XLEN-1:0]   upd_target,
   input  logic              upd_mispredict,
   input  logic              flush_all,
   output logic [PERF_W-1:0] perf_branches,
   output logic [PERF_W-1:0] perf_mispred
);

   localparam int IDX_BITS = $clog2(ENTRIES);
   localparam int ENTRY_W  = entry_width(XLEN, TAG_BITS, CTR_BITS);
   localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
   localparam logic [CTR_BITS-1:0] WEAK_T  = CTR_BITS'(ctr_weak_t(CTR_BITS));

   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [TAG_BITS-1:0] tag_d    [ENTRIES];
   logic [XLEN-1:0]     target_q [ENTRIES];
   logic [XLEN-1:0]     target_d [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

   logic [IDX_BITS-1:0] f_idx, u_idx;
   logic [TAG_BITS-1:0] f_tag, u_tag;
   logic [CTR_BITS-1:0] f_ctr;
   logic                f_hit, u_hit;
   upd_kind_e           upd_kind;

   assign f_idx = IDX_BITS'(pc_index(64'(fetch_pc), IDX_BITS));
   assign f_tag = TAG_BITS'(pc_tag(64'(fetch_pc), IDX_BITS, TAG_BITS));
   assign u_idx = IDX_BITS'(pc_index(64'(upd_pc), IDX_BITS));
   assign u_tag = TAG_BITS'(pc_tag(64'(upd_pc), IDX_BITS, TAG_BITS));

   // Lookup reads the registered table, so a same-cycle update is not visible yet.
   assign f_ctr       = ctr_q[f_idx];
   assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign pred_taken  = !reset && f_hit && (f_ctr >= WEAK_T);
   assign pred_target = pred_taken ? target_q[f_idx] : '0;

   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   always_comb begin
      upd_kind = UPD_NONE;
      if (upd_valid && !flush_all && !reset) begin
         if (u_hit)
            upd_kind = upd_taken ? UPD_HIT_INC : UPD_HIT_DEC;
         else if (upd_taken)
            upd_kind = UPD_ALLOC;
      end
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      if (flush_all) begin
         valid_d = '0;
      end else begin
         case (upd_kind)
            UPD_HIT_INC: target_d[u_idx] = upd_target;
            UPD_ALLOC: begin
               valid_d[u_idx]  = 1'b1;
               tag_d[u_idx]    = u_tag;
               target_d[u_idx] = upd_target;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= '0;
         tag_q    <= '{default: '0};
         target_q <= '{default: '0};
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
      end
   end

   for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
      logic sel;
      assign sel = (u_idx == IDX_BITS'(g));
      sat_counter #(.W(CTR_BITS), .RST_VAL(WEAK_NT)) u_ctr (
         .clk        (clk),
         .reset      (reset),
         .clear_i    (flush_all),
         .inc_i      (sel && (upd_kind == UPD_HIT_INC)),
         .dec_i      (sel && (upd_kind == UPD_HIT_DEC)),
         .load_i     (sel && (upd_kind == UPD_ALLOC)),
         .load_val_i (WEAK_T),
         .cnt_o      (ctr_q[g])
      );
   end

   sat_counter #(.W(PERF_W), .RST_VAL('0)) u_perf_br (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (1'b0),
      .inc_i      (upd_valid),
      .dec_i      (1'b0),
      .load_i     (1'b0),
      .load_val_i ('0),
      .cnt_o      (perf_branches)
   );

   sat_counter #(.W(PERF_W), .RST_VAL('0)) u_perf_mp (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (1'b0),
      .inc_i      (upd_valid && upd_mispredict),
      .dec_i      (1'b0),
      .load_i     (1'b0),
      .load_val_i ('0),
      .cnt_o      (perf_mispred)
   );

   if (ENTRY_W <= 0) begin : g_bad_width
      $error("branch_predictor_btb: entry width must be positive");
   end

endmodule
